mult_seq_ctrl: RTL and testbench
================================

# mult_seq_ctrl

Sequential 4x4 unsigned shift-add multiplier controller with its accumulate/shift datapath. Captures two 4-bit operands on a start handshake and zero-extends the multiplicand to 8 bits. Runs one add-shift iteration per clock and presents the 8-bit product with a one-cycle done pulse. Sits between the operand source and the product consumer as the sequential alternative to the combinational array multiplier.

## Interface
- WIDTH, 4, operand width; product width is 2*WIDTH.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin a multiply; accepted only when ready=1.
- a  input  WIDTH  multiplicand; sampled on the accepting edge.
- b  input  WIDTH  multiplier; sampled on the accepting edge.
- ready  output  1  high only in IDLE.
- done  output  1  one-cycle pulse when the product becomes valid.
- product  output  2*WIDTH  result; holds its value until the next accepted start.

## Operation
- The controller has three states: IDLE, RUN and DONE.
- IDLE:
  - ready=1.
  - When start=1 at a rising edge:
    - mcand <= {WIDTH zeros, a}, which is the zero-extended multiplicand.
    - mplr <= b.
    - acc <= 0.
    - cnt <= 0.
    - The state moves to RUN.
  - When start=0, all registers hold.
- RUN, one iteration per edge:
  - If mplr[0]=1: acc <= acc + mcand. The sum is taken modulo 2^(2*WIDTH); overflow cannot occur for unsigned operands.
  - mcand <= mcand << 1. A zero is shifted in at the LSB and the MSB is discarded.
  - mplr <= mplr >> 1. A zero is shifted in at the MSB.
  - cnt <= cnt + 1.
  - When cnt = WIDTH-1 at the edge, the final iteration executes and the state moves to DONE.
- DONE:
  - done=1 and product=acc (final value). ready=0.
  - The state returns to IDLE on the next edge unconditionally.
- start is ignored in RUN and DONE. It is not queued.
- product is a registered copy of acc, loaded on entry to DONE. It is not updated during RUN.
- No early termination when mplr=0: latency is fixed.
- Reset is asynchronous and clears the following:
  - state=IDLE
  - mcand, mplr, acc, cnt = 0
  - product=0
  - done=0
  - ready=1 (IDLE decode)
- A reset asserted mid-RUN or in DONE aborts the operation. No done pulse is produced for the aborted operation.

## Timing
- E0 is the edge on which start is accepted (state was IDLE with start=1).
- RUN iterations occur on edges E1..EWIDTH. For WIDTH=4 these are E1..E4.
- state=DONE, done=1 and product valid during the cycle after E4. For WIDTH=4 the latency is WIDTH+1 = 5 edges from acceptance to done.
- On E5 the state returns to IDLE and ready=1. A new start is accepted at E6 at the earliest.
- Throughput is one product per WIDTH+2 cycles.
- ready and done are Moore outputs decoded from the state register. There are no combinational paths from start, a or b to any output.
- cnt width is clog2(WIDTH); for the default it is 2 bits.

## Structure
- Shared package `mult_pkg`:
  - state typedef: IDLE=2'b00, RUN=2'b01, DONE=2'b10. Encoding 2'b11 is illegal and decodes to IDLE.
  - WIDTH default constant.
  - product width constant PW = 2*WIDTH.
- Sub-module `mult_seq_datapath` (operations only, no control decisions):
  - mcand/mplr/acc registers.
  - zero-extension of a.
  - adder and shifters.
- Datapath control inputs:
  - load: capture operands, clear acc.
  - step: one add-shift iteration.
  - latch: acc -> product.
- Datapath status output: lsb (mplr[0]).
- `mult_seq_ctrl` owns the FSM and cnt, and drives load, step and latch.

## Test plan
- Reset, then start with a=4'hF, b=4'hF:
  - ready drops after E0.
  - done pulses exactly in the cycle after E4 with product=8'hE1 (225).
  - ready=1 again after E5.
- a=4'h8, b=4'h5: product=8'h28 (40). a=4'h0, b=4'h9: product=8'h00, with done still at E4+1 (fixed latency).
- With a=3, b=2, hold start=1 continuously with new operands a=4'h7, b=4'h3 presented during RUN/DONE:
  - the first product is 8'h06;
  - the second operation starts at E6 with the operands present then (7*3 = 8'h15);
  - mid-run operand changes have no effect.
- Assert rst asynchronously (between edges) at E2 of a 4'hF*4'hF run:
  - immediately: state=IDLE, product=0, done=0, ready=1;
  - no done pulse follows;
  - the next multiply (4'hA*4'h3 = 8'h1E) completes correctly.
- After done for 9*7 (8'h3F), keep start low for 10 cycles: product stays 8'h3F, done stays 0.
- Exhaustive sweep of all 256 a,b pairs against a reference a*b: every product matches, and done occurs exactly once per accepted start.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   WIDTH   : default operand width
//   PW      : default product width (2*WIDTH)
//   state_t : controller state encoding (2'b11 is illegal and decodes to IDLE)
package mult_pkg;

    localparam int WIDTH = 4;
    localparam int PW    = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/mult_seq_datapath.sv
// Accumulate/shift datapath for the sequential multiplier. It performs
// operations only; every decision about when to do them comes from the controller.
//   clk, rst : clock, asynchronous active-high reset
//   load     : capture a (zero-extended) and b, clear the accumulator
//   step     : one add-shift iteration
//   latch    : copy the accumulator's next value into product
//   a, b     : multiplicand, multiplier
//   lsb      : current multiplier LSB (status)
//   product  : registered result
module mult_seq_datapath #(
    parameter int WIDTH = mult_pkg::WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic                 latch,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 lsb,
    output logic [2*WIDTH-1:0]   product
);

    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplr_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_next;

    assign lsb = mplr_q[0];

    // Sum wraps modulo 2^(2*WIDTH); it cannot actually overflow for
    // unsigned operands, so no carry out is kept.
    assign acc_next = mplr_q[0] ? (acc_q + mcand_q) : acc_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others within the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
        end else if (load) begin
            mcand_q <= {{WIDTH{1'b0}}, a};
            mplr_q  <= b;
            acc_q   <= '0;
        end else if (step) begin
            acc_q   <= acc_next;
            mcand_q <= mcand_q << 1;
            mplr_q  <= mplr_q >> 1;
        end
    end

    // latch coincides with the final step, so the product takes the value
    // the accumulator is receiving on that same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            product <= '0;
        end else if (latch) begin
            product <= acc_next;
        end
    end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential WIDTHxWIDTH unsigned shift-add multiplier: controller FSM and
// iteration counter, driving the accumulate/shift datapath.
//   clk, rst : clock, asynchronous active-high reset
//   start    : begin a multiply (accepted only while ready)
//   a, b     : multiplicand, multiplier, sampled on the accepting edge
//   ready    : high in IDLE
//   done     : one-cycle pulse while the product is first valid
//   product  : result, held until the next accepted start completes
// Latency is fixed at WIDTH+1 edges from acceptance to done.
module mult_seq_ctrl #(
    parameter int WIDTH = mult_pkg::WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 ready,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    import mult_pkg::*;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic          load;
    logic          step;
    logic          latch;
    logic          last;
    // The schedule is fixed-length, so the multiplier LSB is not needed here.
    logic          lsb_unused;

    assign last = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= '0;
        end else if (step) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        done    = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        latch   = 1'b0;
        case (state_q)
            RUN: begin
                step = 1'b1;
                if (last) begin
                    latch   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                // IDLE, and the illegal encoding which recovers to IDLE.
                ready   = 1'b1;
                state_d = IDLE;
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
        endcase
    end

    mult_seq_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .step    (step),
        .latch   (latch),
        .a       (a),
        .b       (b),
        .lsb     (lsb_unused),
        .product (product)
    );

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl (WIDTH=4): directed table of
// products, handshake/latency corner sequences and an exhaustive sweep.
module tb_mult_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       ready;
    logic       done;
    logic [7:0] product;

    int n_cmp  = 0;
    int n_fail = 0;
    int done_seen = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] p;
    } vec_t;

    vec_t vecs [8];

    mult_seq_ctrl #(.WIDTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_seen++;
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // One complete multiply: present operands, pulse start for one cycle,
    // then confirm fixed latency, product value and return to IDLE.
    task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_v, input logic [7:0] exp, input string tag);
        int lat;
        @(negedge clk);
        check({tag, " ready_before"}, 32'(ready), 32'd1);
        a = ta; b = tb_v; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, " ready_after_E0"}, 32'(ready), 32'd0);
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'd5);
        check({tag, " product"}, 32'(product), 32'(exp));
        @(negedge clk);
        check({tag, " done_one_cycle"}, 32'(done), 32'd0);
        check({tag, " ready_after_E5"}, 32'(ready), 32'd1);
    endtask

    initial begin
        int lat;
        int base;
        vecs[0] = '{4'hF, 4'hF, 8'hE1};
        vecs[1] = '{4'h8, 4'h5, 8'h28};
        vecs[2] = '{4'h0, 4'h9, 8'h00};
        vecs[3] = '{4'h9, 4'h0, 8'h00};
        vecs[4] = '{4'h1, 4'h1, 8'h01};
        vecs[5] = '{4'hF, 4'h1, 8'h0F};
        vecs[6] = '{4'h1, 4'hF, 8'h0F};
        vecs[7] = '{4'hA, 4'h3, 8'h1E};

        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        #1;
        check("reset ready", 32'(ready), 32'd1);
        check("reset done", 32'(done), 32'd0);
        check("reset product", 32'(product), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));
        end

        // start held high, operands change during RUN/DONE.
        @(negedge clk);
        a = 4'h3; b = 4'h2; start = 1'b1;
        @(negedge clk);
        a = 4'h7; b = 4'h3;
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("held first latency", 32'(lat), 32'd5);
        check("held first product", 32'(product), 32'h06);
        @(negedge clk);
        check("held ready at E5", 32'(ready), 32'd1);
        @(negedge clk);
        check("held accepted at E6", 32'(ready), 32'd0);
        start = 1'b0; a = 4'h0; b = 4'h0;
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("held second latency", 32'(lat), 32'd5);
        check("held second product", 32'(product), 32'h15);
        @(negedge clk);

        // Asynchronous reset between edges after E2 of a 15*15 run.
        @(negedge clk);
        a = 4'hF; b = 4'hF; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort state", 32'(dut.state_q), 32'd0);
        check("abort ready", 32'(ready), 32'd1);
        check("abort done", 32'(done), 32'd0);
        check("abort product", 32'(product), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        base = done_seen;
        repeat (8) @(negedge clk);
        check("abort no done", 32'(done_seen), 32'(base));
        run_op(4'hA, 4'h3, 8'h1E, "after_abort");

        // Product holds while idle.
        run_op(4'h9, 4'h7, 8'h3F, "hold");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("hold product c%0d", i), 32'(product), 32'h3F);
            check($sformatf("hold done c%0d", i), 32'(done), 32'd0);
        end

        // Exhaustive sweep against a reference multiply.
        base = done_seen;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                logic [7:0] ref_p;
                ref_p = 8'(i * j);
                run_op(4'(i), 4'(j), ref_p, $sformatf("sweep %0d*%0d", i, j));
            end
        end
        check("sweep done count", 32'(done_seen - base), 32'd256);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
